sram_sync: RTL

Synchronous, parametrised single-port SRAM that supersedes the asynchronous chip-select SRAM model for clocked designs. It has separate read and write data buses instead of a tri-state bus, a per-bit write mask, a configurable read-latency pipeline and a valid/ready request handshake. A clear state machine sweeps the array to a known value after reset or on command. It sits between any clocked master (CPU, DMA, test sequencer) and on-chip storage.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_rd_pipe.sv | 48 ++++
 rtl/sram_sync.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the synchronous SRAM: controller states
// and the read-latency legality check.
package sram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RD_LAT_MAX = 32'd4;

  function automatic logic rd_lat_ok(input int lat);
    return (lat >= 32'sd1) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-response pipeline: LAT stages of {valid, data}. The data of a stage only
// moves with a valid token, so the last stage holds the most recent response.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              samp_valid,
  input  logic [DATA_W-1:0] samp_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);

  if (!rd_lat_ok(LAT)) begin : g_bad_lat
    $error("sram_rd_pipe: read latency out of range 1..4");
  end

  logic [LAT-1:0]    valid_r;
  logic [DATA_W-1:0] data_r [LAT];

  // Shift tokens one stage per cycle; reset flushes every pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= samp_valid;
      if (samp_valid) begin
        data_r[0] <= samp_data;
      end
      for (int i = 1; i < LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign rsp_valid = valid_r[LAT-1];
  assign rsp_data  = data_r[LAT-1];

endmodule

// File: rtl/sram_sync.sv
// Synchronous single-port SRAM with bit-masked writes, pipelined reads,
// a valid/ready request port and a sweep engine that fills the array with CLEAR_VAL.
module sram_sync
  import sram_pkg::*;
#(
  parameter int                ADDR_W         = 8,
  parameter int                DATA_W         = 4,
  parameter int                RD_LAT         = 1,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  input  logic              clr_start,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int            DEPTH     = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam state_e        RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W:0]   cnt_r;
  logic              ready_r;
  logic              busy_r;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept_s;
  logic              rd_fire_s;
  logic              wr_fire_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  assign accept_s  = req_valid & ready_r;
  assign rd_fire_s = accept_s & ~req_we;
  assign wr_fire_s = accept_s & req_we;
  assign rd_word_s = mem[req_addr];

  // Next-state: a sweep ends after its last word; clr_start only counts in READY.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_READY: begin
        if (clr_start) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_READY;
        end
      end
      default: state_nxt_s = RST_STATE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RST_STATE;
      ready_r <= 1'b0;
      busy_r  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_READY);
      busy_r  <= (state_nxt_s == ST_CLEAR);
    end
  end

  // Sweep counter is parked at zero outside CLEAR so every sweep starts at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      cnt_r <= cnt_r + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      cnt_r <= '0;
    end
  end

  // Single write port shared by the sweep and masked request writes.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (state_r == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_r[ADDR_W-1:0];
      mem_wdata_s = CLEAR_VAL;
    end else if (wr_fire_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = req_addr;
      mem_wdata_s = (rd_word_s & ~req_wmask) | (req_wdata & req_wmask);
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Storage is never reset; reset only suppresses a write in that cycle.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (RD_LAT)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .samp_valid (rd_fire_s),
    .samp_data  (rd_word_s),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data)
  );

  assign req_ready = ready_r;
  assign busy      = busy_r;

endmodule
